// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative 32-bit DIV/DIVU unit for the EXE stage.
// Restoring division at one quotient bit per cycle with a fixed 32-cycle
// busy phase. It produces the quotient on LO and the remainder on HI, and
// holds the pipeline through a combinational stall until DONE.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE_DivReq,
  input  logic             EXE_DivSigned,
  input  logic [WIDTH-1:0] EXE_ResultA,
  input  logic [WIDTH-1:0] EXE_ResultB,
  input  logic             EXE_Advance,
  input  logic             ExceptionAssert,
  output logic [WIDTH-1:0] EXE_MULTDIVtoLO,
  output logic [WIDTH-1:0] EXE_MULTDIVtoHI,
  output logic             EXE_Finish,
  output logic             EXE_MULTDIVStall
);

  localparam int CW = $clog2(ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d; // dividend as supplied, for divide-by-zero
  logic             neg_q_q, neg_q_d;    // quotient must be negated
  logic             neg_r_q, neg_r_d;    // remainder must be negated
  logic             zero_q, zero_d;      // divisor was zero
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  // Operand magnitudes and sign bookkeeping used when a request is accepted
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = EXE_DivSigned & EXE_ResultA[WIDTH-1];
    b_neg = EXE_DivSigned & EXE_ResultB[WIDTH-1];
    a_mag = a_neg ? -EXE_ResultA : EXE_ResultA;
    b_mag = b_neg ? -EXE_ResultB : EXE_ResultB;
  end

  // One restoring-division step: shift {rem, quo} left, trial-subtract divisor.
  // The shifted remainder needs WIDTH+1 bits; the top bit of the difference
  // is clear exactly when the subtraction succeeds.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    ge      = ~diff[WIDTH];
    rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
    q_fix   = zero_q  ? '1        : (neg_q_q ? -quo_nxt : quo_nxt);
    r_fix   = zero_q  ? dvd_raw_q : (neg_r_q ? -rem_nxt : rem_nxt);
  end

  // FSM next state, operand capture, iteration and result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_raw_d = dvd_raw_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    zero_d    = zero_q;
    lo_d      = lo_q;
    hi_d      = hi_q;

    if (ExceptionAssert) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (EXE_DivReq) begin
            quo_d     = a_mag;
            dvs_d     = b_mag;
            dvd_raw_d = EXE_ResultA;
            neg_q_d   = a_neg ^ b_neg;
            neg_r_d   = a_neg;
            zero_d    = (EXE_ResultB == '0);
            rem_d     = '0;
            cnt_d     = CW'(ITER - 1);
            state_d   = S_BUSY;
          end
        end
        S_BUSY: begin
          if (!EXE_DivReq) begin
            state_d = S_IDLE;
          end else begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            if (cnt_q == '0) begin
              state_d = S_DONE;
              lo_d    = q_fix;
              hi_d    = r_fix;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        S_DONE: begin
          // A request held across a stall must not restart the division
          if (EXE_Advance || !EXE_DivReq) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      zero_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_raw_q <= dvd_raw_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      zero_q    <= zero_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  // Output drive: registered results, combinational stall
  always_comb begin
    EXE_MULTDIVtoLO  = lo_q;
    EXE_MULTDIVtoHI  = hi_q;
    EXE_Finish       = (state_q == S_DONE);
    EXE_MULTDIVStall = EXE_DivReq & ~ExceptionAssert & (state_q != S_DONE);
  end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative 32-bit signed/unsigned divider that serves the EXE stage's DIV/DIVU requests. It responds to the EXE-side stall/finish handshake. It latches operands on request, runs a fixed-latency restoring division at one quotient bit per cycle, and presents quotient and remainder as the LO and HI values. It sits beside the ALU in the execute stage; the EXE stage holds the instruction and stalls the pipeline until this block reports completion.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `ITER`, 32, iteration count; must equal `WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `EXE_DivReq`  in  1  level request; high while a DIV/DIVU occupies EXE.
- `EXE_DivSigned`  in  1  1 = DIV (signed), 0 = DIVU; sampled with operands.
- `EXE_ResultA`  in  32  dividend (forwarded rs value).
- `EXE_ResultB`  in  32  divisor (forwarded rt value).
- `EXE_Advance`  in  1  EXE pipeline register loads a new instruction this cycle.
- `ExceptionAssert`  in  1  flush; aborts any in-flight division.
- `EXE_MULTDIVtoLO`  out  32  quotient.
- `EXE_MULTDIVtoHI`  out  32  remainder.
- `EXE_Finish`  out  1  results valid (state DONE).
- `EXE_MULTDIVStall`  out  1  combinational stall request to hazard unit.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - With `EXE_DivReq`=1 and `ExceptionAssert`=0: latch |A|, |B| (magnitudes only if signed), sign of quotient (sA^sB), sign of remainder (sA), and a zero-divisor flag.
  - Clear the partial remainder, load counter=31, go to BUSY.
- BUSY, each cycle:
  - Shift {rem, dividend} left by 1.
  - If rem ≥ divisor: rem -= divisor, quotient bit = 1.
  - Decrement counter. At counter==0, go to DONE.
- DONE:
  - Outputs are sign-corrected, registered and held stable.
  - Go to IDLE when `EXE_Advance`=1 or `EXE_DivReq`=0. Stay otherwise.
  - Never restart on a request held high across a pipeline stall.
- Request behaviour:
  - `EXE_DivReq` dropping during BUSY without a flush: abort to IDLE; outputs unchanged.
  - Operand changes during BUSY are ignored; only latched values are used.
- Sign rules:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed: Q=0x80000000, R=0. Magnitude is treated as unsigned, no trap.
- Divide by zero, both modes: Q=0xFFFFFFFF, R=dividend as supplied. Same latency, no exception.
- `EXE_MULTDIVStall` = `EXE_DivReq` & ~`ExceptionAssert` & (state != DONE).
- `EXE_Finish` = (state == DONE).
- Flush: `ExceptionAssert`=1 in any state forces IDLE next cycle. Stall is low that cycle; LO/HI are not updated.

## Timing
- Reset: state IDLE, counter 0, LO=0, HI=0, `EXE_Finish`=0. `EXE_MULTDIVStall` follows its equation (0 with no request).
- Request first seen in IDLE at cycle T:
  - BUSY during T+1..T+32.
  - DONE from T+33: `EXE_Finish`=1 and LO/HI valid.
  - Stall high T..T+32, low from T+33.
- Fixed 33-cycle stall for every division, including zero divisor; no early termination.
- Back-to-back divisions:
  - DONE at cycle D with `EXE_Advance`=1 → IDLE at D+1.
  - New request accepted at D+1 → DONE at D+34.
- `rst` and `ExceptionAssert` in the same cycle: reset wins, LO/HI cleared.
- `ExceptionAssert` in DONE: IDLE next cycle; LO/HI keep the completed values.

## Test plan
- Unsigned: DIVU 100/7 at T → stall high T..T+32; at T+33 `EXE_Finish`=1, LO=14, HI=2.
- Signed rounding: DIV 0xFFFFFFF9 / 2 (−7/2) → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIV 7 / 0xFFFFFFFE → LO=0xFFFFFFFD, HI=1.
- Overflow and zero divisor:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234, at T+33.
- Flush mid-operation:
  - `ExceptionAssert` at T+10 → IDLE at T+11, `EXE_Finish` never asserts, LO/HI unchanged.
  - New request at T+12 → completes at T+45.
- Held DONE: after completion, keep `EXE_DivReq`=1 and `EXE_Advance`=0 for 3 cycles → `EXE_Finish`=1, stall=0, LO/HI stable, no restart. `EXE_Advance`=1 → IDLE next cycle.
- Back-to-back plus reset: second DIVU 50/5 at D+1 → LO=10, HI=0 at D+34. `rst` asserted during a later BUSY → next cycle IDLE, LO=HI=0, `EXE_Finish`=0.
